// File: rtl/iter_shifter.sv
// iter_shifter
// ------------
// Multi-cycle barrel-shift replacement for the MIPS datapath. It moves the
// operand one bit position per clock under a start/ready/done handshake and
// serves the sll/srl/sra and variable-shift instructions, plus rotate right.
//
// Parameters:
//   WIDTH  - data width in bits (power of two, at least 4)
//   SHW    - width of the shift amount, derived from WIDTH (not overridable)
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-high reset, returns the unit to IDLE
//   start  - request, only looked at while ready is high
//   mode   - 00 SLL, 01 SRL, 10 SRA, 11 ROR
//   amt    - shift amount, 0..WIDTH-1
//   data   - operand
//   ready  - high only while idle and able to accept a request
//   done   - one-cycle pulse in the cycle result is updated
//   result - last completed result, held until the next completion

module iter_shifter #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [SHW-1:0]   amt,
    input  logic [WIDTH-1:0] data,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    localparam logic [SHW-1:0] CNT_ZERO = '0;
    localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);

    state_t           state;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_next;
    logic [SHW-1:0]   count;
    logic [1:0]       mode_q;

    // One-position shift of the working register, selected by the mode that
    // was captured when the request was accepted. Only the fill bit differs
    // between the three right-shift flavours.
    always_comb begin
        work_next = work;
        case (mode_q)
            MODE_SLL: work_next = {work[WIDTH-2:0], 1'b0};
            MODE_SRL: work_next = {1'b0, work[WIDTH-1:1]};
            MODE_SRA: work_next = {work[WIDTH-1], work[WIDTH-1:1]};
            MODE_ROR: work_next = {work[0], work[WIDTH-1:1]};
            default:  work_next = work;
        endcase
    end

    // Control FSM with registered handshake outputs. The result register is
    // written on the same edge that enters DONE, so done and the new result
    // become visible together. When count is 1 the current edge performs the
    // final shift, which is why the shifted value (not the working register)
    // is what lands in result on that transition. A zero amount skips SHIFT
    // entirely and copies the operand straight through.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            ready  <= 1'b1;
            done   <= 1'b0;
            result <= '0;
            count  <= CNT_ZERO;
            work   <= '0;
            mode_q <= MODE_SLL;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        work   <= data;
                        mode_q <= mode;
                        ready  <= 1'b0;
                        if (amt == CNT_ZERO) begin
                            result <= data;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            count <= amt;
                            state <= SHIFT;
                        end
                    end
                end

                SHIFT: begin
                    work  <= work_next;
                    count <= count - CNT_ONE;
                    if (count == CNT_ONE) begin
                        result <= work_next;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end

                default: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_shifter.sv
// tb_iter_shifter
// ---------------
// Self-checking bench for iter_shifter (WIDTH=32). A table of directed
// vectors with hand-computed results covers every mode, plus hand-written
// sequences for the ignored mid-operation start, back-to-back requests held
// on start, and reset asserted in the middle of a shift.

module tb_iter_shifter;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  mode;
    logic [4:0]  amt;
    logic [31:0] data;
    logic        ready;
    logic        done;
    logic [31:0] result;

    int testCount;
    int failCount;

    typedef struct {
        logic [1:0]  m;
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] expRes;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs[NVEC];

    iter_shifter #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mode   (mode),
        .amt    (amt),
        .data   (data),
        .ready  (ready),
        .done   (done),
        .result (result)
    );

    // Free-running 10 ns clock; inputs change and outputs are sampled on the
    // falling edge, half a cycle away from the active edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Issues one request in cycle 0, scrambles the inputs right after
    // acceptance, then waits (bounded) for done. lat is the cycle in which
    // done was seen, busyOk is cleared if ready was high while busy.
    task automatic applyStimulus(input logic [1:0] m, input logic [4:0] a,
                                 input logic [31:0] d, output int lat,
                                 output logic [31:0] res, output logic busyOk);
        @(negedge clk);
        mode  = m;
        amt   = a;
        data  = d;
        start = 1'b1;
        checkOutput("ready_cycle0", {31'd0, ready}, 32'd1);
        @(negedge clk);
        start  = 1'b0;
        mode   = ~m;
        amt    = ~a;
        data   = ~d;
        lat    = 1;
        busyOk = 1'b1;
        while (!done && lat < 100) begin
            if (ready) busyOk = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (ready) busyOk = 1'b0;
        res = result;
    endtask

    initial begin
        int          lat;
        logic [31:0] res;
        logic        busyOk;
        int          doneCnt;
        int          doneCyc;
        int          doneCyc2;
        logic [31:0] doneRes;

        testCount = 0;
        failCount = 0;

        vecs[0]  = '{2'b00, 5'd2,  32'h0000_0002, 32'h0000_0008};
        vecs[1]  = '{2'b00, 5'd2,  32'h0000_0004, 32'h0000_0010};
        vecs[2]  = '{2'b10, 5'd4,  32'h8000_0000, 32'hF800_0000};
        vecs[3]  = '{2'b01, 5'd4,  32'h8000_0000, 32'h0800_0000};
        vecs[4]  = '{2'b11, 5'd1,  32'h0000_0001, 32'h8000_0000};
        vecs[5]  = '{2'b11, 5'd31, 32'h0000_0001, 32'h0000_0002};
        vecs[6]  = '{2'b00, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[7]  = '{2'b01, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[8]  = '{2'b10, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[9]  = '{2'b11, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[10] = '{2'b00, 5'd1,  32'h8000_0001, 32'h0000_0002};
        vecs[11] = '{2'b10, 5'd4,  32'h4000_0000, 32'h0400_0000};
        vecs[12] = '{2'b11, 5'd4,  32'h1234_5678, 32'h8123_4567};
        vecs[13] = '{2'b01, 5'd31, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[14] = '{2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF};
        vecs[15] = '{2'b00, 5'd4,  32'hDEAD_BEEF, 32'hEADB_EEF0};

        // Reset state while reset is held.
        reset = 1'b1;
        start = 1'b0;
        mode  = 2'b00;
        amt   = 5'd0;
        data  = 32'd0;
        #1;
        checkOutput("reset_ready",  {31'd0, ready}, 32'd1);
        checkOutput("reset_done",   {31'd0, done},  32'd0);
        checkOutput("reset_result", result,         32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven vectors: result, latency amt+1, busy while working,
        // single-cycle done and ready again in cycle amt+2.
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].m, vecs[i].a, vecs[i].d, lat, res, busyOk);
            checkOutput($sformatf("vec%0d_result", i), res, vecs[i].expRes);
            checkOutput($sformatf("vec%0d_latency", i), lat, vecs[i].a + 1);
            checkOutput($sformatf("vec%0d_busy", i), {31'd0, busyOk}, 32'd1);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_done_pulse", i), {31'd0, done}, 32'd0);
            checkOutput($sformatf("vec%0d_ready_back", i), {31'd0, ready}, 32'd1);
            checkOutput($sformatf("vec%0d_result_held", i), result, vecs[i].expRes);
        end

        // A start pulsed in cycle 3 of an 8-step SLL must be dropped.
        @(negedge clk);
        mode  = 2'b00;
        amt   = 5'd8;
        data  = 32'h0000_0001;
        start = 1'b1;
        doneCnt = 0;
        doneCyc = -1;
        doneRes = 32'd0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                doneCnt++;
                if (doneCyc < 0) begin
                    doneCyc = c;
                    doneRes = result;
                end
            end
            if (c == 3) begin
                start = 1'b1;
                data  = 32'hFFFF_FFFF;
                mode  = 2'b11;
                amt   = 5'd3;
            end
        end
        checkOutput("ignored_start_result",   doneRes, 32'h0000_0100);
        checkOutput("ignored_start_done_cnt", doneCnt, 32'd1);
        checkOutput("ignored_start_done_cyc", doneCyc, 32'd9);
        checkOutput("ignored_start_final",    result,  32'h0000_0100);

        // Start held high: second acceptance in cycle amt+2 = 3, so done
        // pulses in cycles 2 and 5.
        @(negedge clk);
        mode  = 2'b00;
        amt   = 5'd1;
        data  = 32'h0000_0003;
        start = 1'b1;
        doneCnt  = 0;
        doneCyc  = -1;
        doneCyc2 = -1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 3) checkOutput("b2b_ready_cycle3", {31'd0, ready}, 32'd1);
            if (done) begin
                doneCnt++;
                if (doneCyc < 0) doneCyc = c;
                else doneCyc2 = c;
            end
            if (c == 3) data = 32'h0000_0005;
        end
        start = 1'b0;
        checkOutput("b2b_done_cnt",  doneCnt,  32'd2);
        checkOutput("b2b_done_cyc1", doneCyc,  32'd2);
        checkOutput("b2b_done_cyc2", doneCyc2, 32'd5);
        checkOutput("b2b_result",    result,   32'h0000_000A);
        @(negedge clk);

        // Reset in cycle 5 of a 20-step SRL aborts it with no done pulse.
        @(negedge clk);
        mode  = 2'b01;
        amt   = 5'd20;
        data  = 32'hFFFF_0000;
        start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        #1;
        checkOutput("abort_ready",  {31'd0, ready}, 32'd1);
        checkOutput("abort_done",   {31'd0, done},  32'd0);
        checkOutput("abort_result", result,         32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("abort_ready_after", {31'd0, ready}, 32'd1);
        doneCnt = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done) doneCnt++;
        end
        checkOutput("abort_no_done", doneCnt, 32'd0);
        checkOutput("abort_result_kept", result, 32'd0);
        applyStimulus(2'b01, 5'd20, 32'hFFFF_0000, lat, res, busyOk);
        checkOutput("post_abort_result",  res, 32'h0000_0FFF);
        checkOutput("post_abort_latency", lat, 32'd21);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/iter_shifter.md
# iter_shifter

Parametrised multi-cycle shifter for the MIPS datapath. It generalises the fixed shift-left-by-2 used for branch offsets into a variable-amount unit supporting logical left, logical right, arithmetic right and rotate right. The unit shifts one bit position per clock under a start/ready/done handshake. It sits beside the ALU and serves the sll/srl/sra/sllv/srlv/srav class of instructions, plus rotates, in the multi-cycle datapath.

## Interface
- WIDTH, 32, data width in bits. Must be a power of two, ≥ 4.
- SHW, $clog2(WIDTH), width of the shift amount (localparam; not overridable).
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; forces the block to IDLE immediately
- start  in  1  request; sampled only while ready=1
- mode  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR
- amt  in  SHW  shift amount, 0..WIDTH-1
- data  in  WIDTH  operand
- ready  out  1  high only in IDLE
- done  out  1  one-cycle pulse when result is updated
- result  out  WIDTH  last completed result; held until the next completion

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: ready=1. On a clock edge with start=1, capture data into the working register and capture mode and amt.
  - amt=0: go to DONE.
  - amt≠0: load count=amt and go to SHIFT.
- SHIFT: ready=0. Each edge shifts the working register one position and decrements count. When count reaches 0, go to DONE.
  - SLL: shift left, fill LSB with 0.
  - SRL: shift right, fill MSB with 0.
  - SRA: shift right, fill MSB with a copy of the current MSB.
  - ROR: shift right, fill MSB with the old LSB.
- DONE: ready=0, done=1. result gets the working register on entry, i.e. on the same edge that enters DONE. The next edge returns to IDLE unconditionally.
- start is ignored while ready=0. No queueing; the request is simply lost.
- mode, amt and data are sampled only at acceptance. Changes while busy have no effect.
- result changes only on the edge that enters DONE.
- Amount is always < WIDTH by construction (SHW bits), so there is no out-of-range case.

## Timing
- Reset values: state=IDLE, ready=1, done=0, result=0, count=0, working register=0.
- Reset asserted mid-operation aborts the operation: no done pulse, result keeps 0 (the reset value). After reset deasserts, ready=1 in the first cycle.
- Let cycle 0 be the cycle with start=1 and ready=1. Then:
  - ready=0 from cycle 1 through cycle amt+1.
  - done=1 and the new result are visible in cycle amt+1.
  - ready=1 again in cycle amt+2.
- Latency is amt+1 cycles from the accepting edge to done. Throughput is one operation per amt+2 cycles.
- Back-to-back: a start held high continuously is accepted again in cycle amt+2.
- done is never high for more than one consecutive cycle.
- Outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- SLL, data=0x00000002, amt=2: result=0x00000008, done in cycle 3, ready back in cycle 4. Repeat with data=4, amt=2: result=0x00000010.
- SRA, data=0x80000000, amt=4: result=0xF8000000. SRL with the same operand: result=0x08000000.
- ROR, data=0x00000001, amt=1: result=0x80000000. ROR with amt=31 on 0x00000001: result=0x00000002, done in cycle 32.
- amt=0, data=0xDEADBEEF in any mode: result=0xDEADBEEF, done in cycle 1, ready in cycle 2.
- Start SLL data=1, amt=8. In cycle 3, pulse start with data=0xFFFFFFFF and change mode/amt. The second start is ignored: result=0x00000100, exactly one done pulse.
- Start SRL, amt=20. Assert reset in cycle 5: ready=1, done=0 and result=0 immediately. Over the next 30 cycles, no done pulse appears. A new request then completes normally.
